vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator and output stage. It is the successor to the fixed 640x480 `vga` block.
- Generates the pixel/line counters, the sync pulses and the blanking for any mode set by parameters.
- Exposes the pixel coordinates to an upstream pixel source whose read latency is configurable. Sync, blank and colour are re-aligned so they leave the block on the same cycle.
- Sits between the game/scene renderer and the DAC pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level (0 = active-low)
- PIX_DIV, 1, clock cycles per pixel (1..4)
- DATA_LAT, 1, pixel-source read latency in pixel ticks (0..3)
- COLOR_W, 8, bits per colour channel
- CNT_W, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clock_25  in  1  system clock
- reset_key  in  1  asynchronous, active-low reset
- r_in  in  COLOR_W  red from the pixel source for the (pixel_x, pixel_y) issued DATA_LAT ticks earlier
- g_in  in  COLOR_W  green, same timing as r_in
- b_in  in  COLOR_W  blue, same timing as r_in
- pixel_x  out  CNT_W  current horizontal count, 0..H_TOTAL-1
- pixel_y  out  CNT_W  current vertical count, 0..V_TOTAL-1
- pixel_tick  out  1  one-cycle strobe; counters advance on it
- video_on  out  1  pixel_x<H_ACTIVE && pixel_y<V_ACTIVE (undelayed)
- line_end  out  1  pixel_tick && pixel_x==H_TOTAL-1
- frame_end  out  1  line_end && pixel_y==V_TOTAL-1
- frame_count  out  16  completed frames, wraps 0xFFFF->0
- vga_hs  out  1  horizontal sync, aligned to the colour outputs
- vga_vs  out  1  vertical sync, aligned to the colour outputs
- vga_blank_n  out  1  high while the output pixel is visible
- vga_r  out  COLOR_W  red to the DAC
- vga_g  out  COLOR_W  green to the DAC
- vga_b  out  COLOR_W  blue to the DAC

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; the default is 800.
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP; the default is 525.
- Reset (reset_key low, asynchronous):
  - Counters, divider, frame_count, and all pipeline stages go to 0.
  - vga_hs = ~HS_POL and vga_vs = ~VS_POL.
  - vga_blank_n, vga_r/g/b, pixel_tick, line_end and frame_end = 0.
  - Release is seen on the next clock_25 edge.
- Divider:
  - A mod-PIX_DIV counter drives pixel_tick high on the cycle the divider equals PIX_DIV-1.
  - With PIX_DIV=1, pixel_tick is high on every cycle after reset.
- Counters (update only when pixel_tick is high):
  - pixel_x increments; at H_TOTAL-1 it wraps to 0 and pixel_y increments.
  - pixel_y wraps from V_TOTAL-1 to 0.
  - On that wrap frame_count increments, modulo 2^16.
- Raw sync is computed combinationally from the counters:
  - hs_raw is active when H_ACTIVE+H_FP <= pixel_x < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw is active when V_ACTIVE+V_FP <= pixel_y < V_ACTIVE+V_FP+V_SYNC.
  - vs_raw is line-based: it spans whole lines, including their blanking.
- Alignment pipeline:
  - hs_raw, vs_raw and video_on pass through a DATA_LAT-deep shift register that advances on pixel_tick.
  - The stage-DATA_LAT values are then combined with r_in/g_in/b_in in one final output register, also enabled by pixel_tick.
  - Total latency from counter to pins is DATA_LAT+1 pixel ticks, identical for sync, blank and colour.
- Blanking:
  - vga_r/g/b = delayed video_on ? input : 0.
  - vga_blank_n = delayed video_on.
  - Colour is forced to zero whenever blank, whatever r_in/g_in/b_in carry.
- Polarity: vga_hs = delayed hs_raw XNOR HS_POL. Same rule for vga_vs with VS_POL.
- Registration: all outputs are registered, except video_on, line_end and frame_end, which are combinational from registered state.
- Reset mid-frame:
  - Everything returns to the reset state immediately.
  - After release, counting restarts at (0,0) with no partial-frame artefacts beyond the DATA_LAT+1 fill.
  - During the fill, the pipeline emits blank pixels with inactive sync.
- Inputs change only on the clock; r_in/g_in/b_in are sampled only on pixel_tick cycles.

Test Plan:
- Reset with defaults → pixel_x=0, pixel_y=0, frame_count=0, vga_hs=vga_vs=1, vga_blank_n=0, RGB=0.
- Defaults with PIX_DIV=1, DATA_LAT=1:
  - Period of line_end = 800 cycles.
  - vga_hs is low for exactly 96 cycles, beginning 2 cycles after pixel_x reaches 656.
  - vga_vs is low for 2 lines starting at line 490.
  - frame_end occurs every 420000 cycles.
- Constant r_in=8'hFF with a checker counting vga_r==FF → exactly 640 per visible line, 640*480 per frame, and 0 during lines 480..524.
- Small mode (H 8/1/2/1, V 4/1/1/1), DATA_LAT=3, with a model source returning r_in=pixel_x delayed by 3 → vga_r sequence per line is 0..7 followed by 4 zeros, aligned with vga_blank_n.
- PIX_DIV=2 on the small mode → pixel_tick on alternating cycles; the line lasts 24 cycles; outputs hold for 2 cycles each.
- reset_key pulsed low for 1 cycle mid-line at pixel_x=5, pixel_y=2 → outputs return to reset values asynchronously; the counters restart at 0; vga_blank_n stays low for DATA_LAT+1 ticks; frame_count remains 0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with a configurable-latency
// pixel-source alignment stage. Sync, blank and colour leave on the same
// cycle, DATA_LAT+1 pixel ticks after the counters that produced them.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int PIX_DIV  = 1,
    parameter int DATA_LAT = 1,
    parameter int COLOR_W  = 8,
    parameter int CNT_W    = 10
) (
    input  logic               clock_25,
    input  logic               reset_key,
    input  logic [COLOR_W-1:0] r_in,
    input  logic [COLOR_W-1:0] g_in,
    input  logic [COLOR_W-1:0] b_in,
    output logic [CNT_W-1:0]   pixel_x,
    output logic [CNT_W-1:0]   pixel_y,
    output logic               pixel_tick,
    output logic               video_on,
    output logic               line_end,
    output logic               frame_end,
    output logic [15:0]        frame_count,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               vga_blank_n,
    output logic [COLOR_W-1:0] vga_r,
    output logic [COLOR_W-1:0] vga_g,
    output logic [COLOR_W-1:0] vga_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEGIN = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] VS_BEGIN = CNT_W'(V_ACTIVE + V_FP);
    // One extra bit: the sync end may equal the total when the back porch is 0.
    localparam logic [CNT_W:0]   HS_FINISH = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W:0]   VS_FINISH = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic       HS_ACT   = (HS_POL != 0);
    localparam logic       VS_ACT   = (VS_POL != 0);
    localparam logic [1:0] DIV_LAST = 2'(PIX_DIV - 1);

    logic [1:0]       div_reg;
    logic [1:0]       div_next;
    logic             tick_reg;
    logic [CNT_W-1:0] x_reg;
    logic [CNT_W-1:0] y_reg;
    logic [15:0]      frame_reg;
    logic             hs_raw;
    logic             vs_raw;
    logic             von_raw;
    logic [2:0]       raw_bits;
    logic [2:0]       aligned;
    logic             hs_out_reg;
    logic             vs_out_reg;
    logic             blank_n_reg;
    logic [COLOR_W-1:0] r_out_reg;
    logic [COLOR_W-1:0] g_out_reg;
    logic [COLOR_W-1:0] b_out_reg;

    assign div_next = (div_reg == DIV_LAST) ? 2'd0 : 2'(div_reg + 2'd1);

    // Pixel-clock divider; the tick is registered so it is low during reset
    // and rises on the first edge after release when PIX_DIV is 1.
    always_ff @(posedge clock_25 or negedge reset_key) begin
        if (!reset_key) begin
            div_reg  <= 2'd0;
            tick_reg <= 1'b0;
        end else begin
            div_reg  <= div_next;
            tick_reg <= (div_next == DIV_LAST);
        end
    end

    // Raster counters and completed-frame counter, stepped on each pixel tick.
    always_ff @(posedge clock_25 or negedge reset_key) begin
        if (!reset_key) begin
            x_reg     <= '0;
            y_reg     <= '0;
            frame_reg <= 16'd0;
        end else if (tick_reg) begin
            if (x_reg == H_LAST) begin
                x_reg <= '0;
                if (y_reg == V_LAST) begin
                    y_reg     <= '0;
                    frame_reg <= frame_reg + 16'd1;
                end else begin
                    y_reg <= y_reg + 1'b1;
                end
            end else begin
                x_reg <= x_reg + 1'b1;
            end
        end
    end

    assign von_raw  = (x_reg < H_VIS) && (y_reg < V_VIS);
    assign hs_raw   = (x_reg >= HS_BEGIN) && ({1'b0, x_reg} < HS_FINISH);
    assign vs_raw   = (y_reg >= VS_BEGIN) && ({1'b0, y_reg} < VS_FINISH);
    assign raw_bits = {hs_raw, vs_raw, von_raw};

    generate
        if (DATA_LAT == 0) begin : g_no_delay
            assign aligned = raw_bits;
        end else begin : g_delay
            logic [2:0] stage_reg [DATA_LAT];

            // Delay line matching the pixel source's read latency.
            always_ff @(posedge clock_25 or negedge reset_key) begin
                if (!reset_key) begin
                    for (int i = 0; i < DATA_LAT; i++) stage_reg[i] <= 3'b000;
                end else if (tick_reg) begin
                    stage_reg[0] <= raw_bits;
                    for (int i = 1; i < DATA_LAT; i++) stage_reg[i] <= stage_reg[i-1];
                end
            end

            assign aligned = stage_reg[DATA_LAT-1];
        end
    endgenerate

    // Final output register: polarity, blanking and colour gating together.
    always_ff @(posedge clock_25 or negedge reset_key) begin
        if (!reset_key) begin
            hs_out_reg  <= ~HS_ACT;
            vs_out_reg  <= ~VS_ACT;
            blank_n_reg <= 1'b0;
            r_out_reg   <= '0;
            g_out_reg   <= '0;
            b_out_reg   <= '0;
        end else if (tick_reg) begin
            hs_out_reg  <= ~(aligned[2] ^ HS_ACT);
            vs_out_reg  <= ~(aligned[1] ^ VS_ACT);
            blank_n_reg <= aligned[0];
            r_out_reg   <= aligned[0] ? r_in : '0;
            g_out_reg   <= aligned[0] ? g_in : '0;
            b_out_reg   <= aligned[0] ? b_in : '0;
        end
    end

    assign pixel_x     = x_reg;
    assign pixel_y     = y_reg;
    assign pixel_tick  = tick_reg;
    assign video_on    = von_raw;
    assign line_end    = tick_reg && (x_reg == H_LAST);
    assign frame_end   = line_end && (y_reg == V_LAST);
    assign frame_count = frame_reg;
    assign vga_hs      = hs_out_reg;
    assign vga_vs      = vs_out_reg;
    assign vga_blank_n = blank_n_reg;
    assign vga_r       = r_out_reg;
    assign vga_g       = g_out_reg;
    assign vga_b       = b_out_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default 640x480, small mode
// with DATA_LAT=3, small mode with PIX_DIV=2) checked every cycle against an
// arithmetic raster model, plus a per-pixel table and timing measurements.
module tb_vga_timing_gen;

    localparam int NCYC = 2000;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        tick;
        logic        von;
        logic        le;
        logic        fe;
        logic [15:0] fc;
        logic        hs;
        logic        vs;
        logic        bn;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
    } obs_t;

    typedef struct {
        int         px;
        logic [7:0] exp_r;
        logic       exp_bn;
        logic       exp_hs;
    } vec_t;

    // Mode table per instance
    int ha_p [3] = '{640, 8, 8};
    int hf_p [3] = '{16, 1, 1};
    int hw_p [3] = '{96, 2, 2};
    int hb_p [3] = '{48, 1, 1};
    int va_p [3] = '{480, 4, 4};
    int vf_p [3] = '{10, 1, 1};
    int vw_p [3] = '{2, 1, 1};
    int vb_p [3] = '{33, 1, 1};
    int pd_p [3] = '{1, 1, 2};
    int dl_p [3] = '{1, 3, 2};

    logic        clk = 1'b0;
    logic [2:0]  rst_n;
    logic [23:0] rgb_in [3];
    logic [9:0]  px [3];
    logic [9:0]  py [3];
    logic        tick [3];
    logic        von [3];
    logic        le [3];
    logic        fe [3];
    logic [15:0] fc [3];
    logic        hs [3];
    logic        vs [3];
    logic        bn [3];
    logic [7:0]  vr [3];
    logic [7:0]  vg [3];
    logic [7:0]  vb [3];
    obs_t        obs_arr [3];
    logic [7:0]  tbl [256];
    int          n_cnt [3];
    vec_t        vecs [12];
    int          checks = 0;
    int          errors = 0;

    always #20 clk = ~clk;

    vga_timing_gen u_a (
        .clock_25(clk), .reset_key(rst_n[0]),
        .r_in(rgb_in[0][23:16]), .g_in(rgb_in[0][15:8]), .b_in(rgb_in[0][7:0]),
        .pixel_x(px[0]), .pixel_y(py[0]), .pixel_tick(tick[0]), .video_on(von[0]),
        .line_end(le[0]), .frame_end(fe[0]), .frame_count(fc[0]),
        .vga_hs(hs[0]), .vga_vs(vs[0]), .vga_blank_n(bn[0]),
        .vga_r(vr[0]), .vga_g(vg[0]), .vga_b(vb[0])
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .PIX_DIV(1), .DATA_LAT(3)
    ) u_b (
        .clock_25(clk), .reset_key(rst_n[1]),
        .r_in(rgb_in[1][23:16]), .g_in(rgb_in[1][15:8]), .b_in(rgb_in[1][7:0]),
        .pixel_x(px[1]), .pixel_y(py[1]), .pixel_tick(tick[1]), .video_on(von[1]),
        .line_end(le[1]), .frame_end(fe[1]), .frame_count(fc[1]),
        .vga_hs(hs[1]), .vga_vs(vs[1]), .vga_blank_n(bn[1]),
        .vga_r(vr[1]), .vga_g(vg[1]), .vga_b(vb[1])
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .PIX_DIV(2), .DATA_LAT(2)
    ) u_c (
        .clock_25(clk), .reset_key(rst_n[2]),
        .r_in(rgb_in[2][23:16]), .g_in(rgb_in[2][15:8]), .b_in(rgb_in[2][7:0]),
        .pixel_x(px[2]), .pixel_y(py[2]), .pixel_tick(tick[2]), .video_on(von[2]),
        .line_end(le[2]), .frame_end(fe[2]), .frame_count(fc[2]),
        .vga_hs(hs[2]), .vga_vs(vs[2]), .vga_blank_n(bn[2]),
        .vga_r(vr[2]), .vga_g(vg[2]), .vga_b(vb[2])
    );

    for (genvar gi = 0; gi < 3; gi++) begin : g_obs
        assign obs_arr[gi] = {px[gi], py[gi], tick[gi], von[gi], le[gi], fe[gi], fc[gi],
                              hs[gi], vs[gi], bn[gi], vr[gi], vg[gi], vb[gi]};
    end

    function automatic int htot(int i);
        return ha_p[i] + hf_p[i] + hw_p[i] + hb_p[i];
    endfunction

    function automatic int vtot(int i);
        return va_p[i] + vf_p[i] + vw_p[i] + vb_p[i];
    endfunction

    // Pixel ticks completed after n clock edges since reset release.
    function automatic int ticks_done(int i, int n);
        if (n == 0) return 0;
        return n / pd_p[i] - ((pd_p[i] == 1) ? 1 : 0);
    endfunction

    // Colour the pixel source returns for stream position s.
    function automatic logic [23:0] color_of(int i, int s);
        case (i)
            0:       return {8'hFF, tbl[s % 256], tbl[(s + 77) % 256]};
            1:       return {8'(s % htot(1)), tbl[(s * 5) % 256], tbl[(s + 13) % 256]};
            default: return {tbl[s % 256], tbl[(s + 101) % 256], tbl[(s * 7 + 3) % 256]};
        endcase
    endfunction

    function automatic obs_t model(int i, int n);
        obs_t o;
        int t, x, y, s, sx, sy, ht, vt;
        logic vis;
        ht = htot(i);
        vt = vtot(i);
        t  = ticks_done(i, n);
        x  = t % ht;
        y  = (t / ht) % vt;
        o      = '0;
        o.x    = 10'(x);
        o.y    = 10'(y);
        o.tick = (n > 0) && (n % pd_p[i] == pd_p[i] - 1);
        o.von  = (x < ha_p[i]) && (y < va_p[i]);
        o.le   = o.tick && (x == ht - 1);
        o.fe   = o.le && (y == vt - 1);
        o.fc   = 16'((t / (ht * vt)) % 65536);
        s = t - 1 - dl_p[i];
        if (s < 0) begin
            o.hs = 1'b1;
            o.vs = 1'b1;
            o.bn = 1'b0;
        end else begin
            sx  = s % ht;
            sy  = (s / ht) % vt;
            vis = (sx < ha_p[i]) && (sy < va_p[i]);
            o.hs = !((sx >= ha_p[i] + hf_p[i]) && (sx < ha_p[i] + hf_p[i] + hw_p[i]));
            o.vs = !((sy >= va_p[i] + vf_p[i]) && (sy < va_p[i] + vf_p[i] + vw_p[i]));
            o.bn = vis;
            if (vis) {o.r, o.g, o.b} = color_of(i, s);
        end
        return o;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_obs(input int i);
        obs_t e;
        e = model(i, n_cnt[i]);
        checks++;
        if (obs_arr[i] !== e) begin
            errors++;
            $display("FAIL sb_inst%0d n=%0d got %h expected %h", i, n_cnt[i], obs_arr[i], e);
        end
    endtask

    task automatic drive_inputs();
        int t;
        obs_t e;
        for (int i = 0; i < 3; i++) begin
            t = ticks_done(i, n_cnt[i]);
            e = model(i, n_cnt[i]);
            if (e.tick && (t - dl_p[i] >= 0)) rgb_in[i] = color_of(i, t - dl_p[i]);
            else rgb_in[i] = 24'($urandom);
            if (i == 0) rgb_in[0][23:16] = 8'hFF;
        end
    endtask

    initial begin
        int le1_a, le2_a, ff_a, c656, fall, low_len;
        int le1_c, le2_c, tick_c;
        bit hs_done, b_pulsed, b_release;
        le1_a = -1; le2_a = -1; ff_a = 0; c656 = -1; fall = -1; low_len = 0;
        le1_c = -1; le2_c = -1; tick_c = 0;
        hs_done = 0; b_pulsed = 0; b_release = 0;

        for (int k = 0; k < 256; k++) tbl[k] = 8'($urandom);
        for (int k = 0; k < 12; k++) begin
            vecs[k].px     = k;
            vecs[k].exp_r  = (k < 8) ? 8'(k) : 8'd0;
            vecs[k].exp_bn = (k < 8);
            vecs[k].exp_hs = !(k >= 9 && k <= 10);
        end

        rst_n = 3'b000;
        for (int i = 0; i < 3; i++) begin
            n_cnt[i]  = 0;
            rgb_in[i] = 24'($urandom);
        end
        repeat (3) @(negedge clk);

        chk("rst_pixel_x", px[0], 0);
        chk("rst_pixel_y", py[0], 0);
        chk("rst_frame_count", fc[0], 0);
        chk("rst_vga_hs", hs[0], 1);
        chk("rst_vga_vs", vs[0], 1);
        chk("rst_blank_n", bn[0], 0);
        chk("rst_rgb", {vr[0], vg[0], vb[0]}, 0);
        for (int i = 0; i < 3; i++) chk_obs(i);
        rst_n = 3'b111;

        for (int cyc = 1; cyc <= NCYC; cyc++) begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) if (rst_n[i]) n_cnt[i]++;
            @(negedge clk);
            for (int i = 0; i < 3; i++) chk_obs(i);

            // Default mode: line period, hsync placement and width, FF count
            if (le1_a >= 0 && le2_a < 0 && vr[0] == 8'hFF) ff_a++;
            if (le[0]) begin
                if (le1_a < 0) le1_a = cyc;
                else if (le2_a < 0) le2_a = cyc;
            end
            if (c656 < 0 && px[0] == 10'd656) c656 = cyc;
            if (fall < 0 && hs[0] == 1'b0) fall = cyc;
            if (fall >= 0 && !hs_done) begin
                if (hs[0] == 1'b0) low_len++;
                else hs_done = 1;
            end

            // Divided small mode: line period and tick count within a line
            if (le1_c >= 0 && le2_c < 0 && tick[2]) tick_c++;
            if (le[2]) begin
                if (le1_c < 0) le1_c = cyc;
                else if (le2_c < 0) le2_c = cyc;
            end

            // Small mode, DATA_LAT=3: one full output line (y=1) per table
            if (rst_n[1] && n_cnt[1] >= 17 && n_cnt[1] < 29) begin
                int k;
                k = n_cnt[1] - 17;
                chk("tbl_vga_r", vr[1], vecs[k].exp_r);
                chk("tbl_blank_n", bn[1], vecs[k].exp_bn);
                chk("tbl_vga_hs", hs[1], vecs[k].exp_hs);
                chk("tbl_pixel_x", px[1], (vecs[k].px + 4) % 12);
                $display("vec %0d px %0d vga_r %0d blank_n %0d hs %0d",
                         k, vecs[k].px, vr[1], bn[1], hs[1]);
            end

            if (b_release) begin
                rst_n[1] = 1'b1;
                b_release = 0;
            end

            // Mid-line reset pulse at pixel (5,2)
            if (!b_pulsed && n_cnt[1] == 30) begin
                b_pulsed = 1;
                chk("pre_rst_x", px[1], 5);
                chk("pre_rst_y", py[1], 2);
                rst_n[1] = 1'b0;
                #1;
                chk("async_rst_x", px[1], 0);
                chk("async_rst_y", py[1], 0);
                chk("async_rst_blank_n", bn[1], 0);
                chk("async_rst_hs", hs[1], 1);
                chk("async_rst_vs", vs[1], 1);
                chk("async_rst_r", vr[1], 0);
                chk("async_rst_tick", tick[1], 0);
                chk("async_rst_fc", fc[1], 0);
                n_cnt[1] = 0;
                b_release = 1;
            end

            drive_inputs();
        end

        chk("line_end_period_a", le2_a - le1_a, 800);
        chk("hs_delay_from_656", fall - c656, 2);
        chk("hs_low_width", low_len, 96);
        chk("ff_pixels_per_line", ff_a, 640);
        chk("line_end_period_c", le2_c - le1_c, 24);
        chk("ticks_per_line_c", tick_c, 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
